// File: rtl/seg_display_pkg.sv
// Shared definitions for the seven-segment display arbiter.
//   state_t   : arbiter FSM states (IDLE shows background, SHOW shows a message)
//   SRC_*     : ACTIVE_SRC encodings reported to the display wrapper
package seg_display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam logic [1:0] SRC_BG   = 2'd0;
  localparam logic [1:0] SRC_MSG1 = 2'd1;
  localparam logic [1:0] SRC_MSG2 = 2'd2;

endpackage

// File: rtl/GenericCounter.sv
// Free-running modulo counter used as a periodic tick source.
//   CLK      : clock
//   RESET    : asynchronous active-high reset, COUNT returns to 0
//   ENABLE   : count enable
//   TRIG_OUT : high for the one cycle in which COUNT equals COUNTER_MAX
module GenericCounter #(
  parameter int unsigned COUNTER_WIDTH = 17,
  parameter int unsigned COUNTER_MAX   = 99999
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE,
  output logic TRIG_OUT
);

  localparam logic [COUNTER_WIDTH-1:0] MAX_V = COUNTER_WIDTH'(COUNTER_MAX);
  localparam logic [COUNTER_WIDTH-1:0] ONE_V = COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] count_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
    end else if (ENABLE) begin
      if (count_q == MAX_V) count_q <= '0;
      else                  count_q <= count_q + ONE_V;
    end
  end

  assign TRIG_OUT = ENABLE && (count_q == MAX_V);

endmodule

// File: rtl/seg_display_arbiter.sv
// Time-shares the 4-digit seven-segment display between a background source
// and two transient message requesters with round-robin tie breaking.
//   CLK, RESET           : clock, asynchronous active-high reset
//   BG_DIGITS            : background digits, shown while idle
//   MSGn_REQ/DIGITS/BLINK: level request, digits and blink enable (n = 1, 2)
//   MSGn_ACK             : one-cycle grant pulse
//   NUM0..NUM3           : registered digits to the display wrapper
//   BLANK                : 1 = segments off (blink off-phase)
//   ACTIVE_SRC           : 0 background, 1 MSG1, 2 MSG2
module seg_display_arbiter
  import seg_display_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned HOLD_MS  = 1000,
  parameter int unsigned BLINK_MS = 250
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] BG_DIGITS,
  input  logic        MSG1_REQ,
  input  logic [15:0] MSG1_DIGITS,
  input  logic        MSG1_BLINK,
  output logic        MSG1_ACK,
  input  logic        MSG2_REQ,
  input  logic [15:0] MSG2_DIGITS,
  input  logic        MSG2_BLINK,
  output logic        MSG2_ACK,
  output logic [3:0]  NUM0,
  output logic [3:0]  NUM1,
  output logic [3:0]  NUM2,
  output logic [3:0]  NUM3,
  output logic        BLANK,
  output logic [1:0]  ACTIVE_SRC
);

  localparam int unsigned HW = $clog2(HOLD_MS + 1);
  localparam int unsigned BW = $clog2(BLINK_MS + 1);

  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MS - 1);
  localparam logic [HW-1:0] HOLD_END   = HW'(HOLD_MS);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

  logic ms_tick;

  GenericCounter #(
    .COUNTER_WIDTH(17),
    .COUNTER_MAX  (TICK_DIV - 1)
  ) u_ms_tick (
    .CLK     (CLK),
    .RESET   (RESET),
    .ENABLE  (1'b1),
    .TRIG_OUT(ms_tick)
  );

  state_t        state_q, state_d;
  logic          grant1, grant2, hold_done;

  logic          rr_msg2_q, rr_msg2_d;     // 1 = MSG2 was served last
  logic [15:0]   msg_digits_q, msg_digits_d;
  logic          msg_blink_q, msg_blink_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [15:0]   num_q, num_d;
  logic          blank_q, blank_d;
  logic [1:0]    src_q, src_d;
  logic          ack1_q, ack1_d, ack2_q, ack2_d;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: arbitration in IDLE, hold expiry in SHOW (no preemption)
  always_comb begin
    state_d   = state_q;
    grant1    = 1'b0;
    grant2    = 1'b0;
    hold_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MSG1_REQ && MSG2_REQ) begin
          grant1 = rr_msg2_q;
          grant2 = !rr_msg2_q;
        end else begin
          grant1 = MSG1_REQ;
          grant2 = MSG2_REQ;
        end
        if (grant1 || grant2) state_d = SHOW;
      end
      SHOW: begin
        if (ms_tick && (hold_cnt_q == HOLD_LAST)) begin
          hold_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; all display outputs are registered
  always_comb begin
    rr_msg2_d    = rr_msg2_q;
    msg_digits_d = msg_digits_q;
    msg_blink_d  = msg_blink_q;
    hold_cnt_d   = hold_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    num_d        = num_q;
    blank_d      = blank_q;
    src_d        = src_q;
    ack1_d       = 1'b0;
    ack2_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        hold_cnt_d  = '0;
        blink_cnt_d = '0;
        blank_d     = 1'b0;
        if (grant1) begin
          msg_digits_d = MSG1_DIGITS;
          msg_blink_d  = MSG1_BLINK;
          num_d        = MSG1_DIGITS;
          src_d        = SRC_MSG1;
          ack1_d       = 1'b1;
          rr_msg2_d    = 1'b0;
        end else if (grant2) begin
          msg_digits_d = MSG2_DIGITS;
          msg_blink_d  = MSG2_BLINK;
          num_d        = MSG2_DIGITS;
          src_d        = SRC_MSG2;
          ack2_d       = 1'b1;
          rr_msg2_d    = 1'b1;
        end else begin
          num_d = BG_DIGITS;
          src_d = SRC_BG;
        end
      end
      SHOW: begin
        if (ms_tick) begin
          if (hold_cnt_q != HOLD_END) hold_cnt_d = hold_cnt_q + HOLD_ONE;
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            if (msg_blink_q) blank_d = !blank_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BLINK_ONE;
          end
        end
        // Expiry overrides the blink toggle so the return cycle is never blank
        if (hold_done) begin
          num_d   = BG_DIGITS;
          src_d   = SRC_BG;
          blank_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rr_msg2_q    <= 1'b0;
      msg_digits_q <= '0;
      msg_blink_q  <= 1'b0;
      hold_cnt_q   <= '0;
      blink_cnt_q  <= '0;
      num_q        <= '0;
      blank_q      <= 1'b0;
      src_q        <= SRC_BG;
      ack1_q       <= 1'b0;
      ack2_q       <= 1'b0;
    end else begin
      rr_msg2_q    <= rr_msg2_d;
      msg_digits_q <= msg_digits_d;
      msg_blink_q  <= msg_blink_d;
      hold_cnt_q   <= hold_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      num_q        <= num_d;
      blank_q      <= blank_d;
      src_q        <= src_d;
      ack1_q       <= ack1_d;
      ack2_q       <= ack2_d;
    end
  end

  assign NUM0       = num_q[3:0];
  assign NUM1       = num_q[7:4];
  assign NUM2       = num_q[11:8];
  assign NUM3       = num_q[15:12];
  assign BLANK      = blank_q;
  assign ACTIVE_SRC = src_q;
  assign MSG1_ACK   = ack1_q;
  assign MSG2_ACK   = ack2_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with TICK_DIV=10, HOLD_MS=4, BLINK_MS=1.
module tb_seg_display_arbiter;

  logic        CLK;
  logic        RESET;
  logic [15:0] BG_DIGITS;
  logic        MSG1_REQ, MSG1_BLINK, MSG1_ACK;
  logic [15:0] MSG1_DIGITS;
  logic        MSG2_REQ, MSG2_BLINK, MSG2_ACK;
  logic [15:0] MSG2_DIGITS;
  logic [3:0]  NUM0, NUM1, NUM2, NUM3;
  logic        BLANK;
  logic [1:0]  ACTIVE_SRC;
  logic [15:0] num_all;

  int checks = 0;
  int errors = 0;

  assign num_all = {NUM3, NUM2, NUM1, NUM0};

  seg_display_arbiter #(
    .TICK_DIV(10),
    .HOLD_MS (4),
    .BLINK_MS(1)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .BG_DIGITS  (BG_DIGITS),
    .MSG1_REQ   (MSG1_REQ),
    .MSG1_DIGITS(MSG1_DIGITS),
    .MSG1_BLINK (MSG1_BLINK),
    .MSG1_ACK   (MSG1_ACK),
    .MSG2_REQ   (MSG2_REQ),
    .MSG2_DIGITS(MSG2_DIGITS),
    .MSG2_BLINK (MSG2_BLINK),
    .MSG2_ACK   (MSG2_ACK),
    .NUM0       (NUM0),
    .NUM1       (NUM1),
    .NUM2       (NUM2),
    .NUM3       (NUM3),
    .BLANK      (BLANK),
    .ACTIVE_SRC (ACTIVE_SRC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] bg;
    logic [15:0] exp_num;
    logic [1:0]  exp_src;
  } bg_vec_t;

  bg_vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // Called right after the grant sample; returns the number of sampled cycles
  // the message was on display (grant cycle included), BLANK toggles seen,
  // toggle intervals that were not one ms (10 cycles), and stray ACKs.
  task automatic wait_idle(input string tag, output int n, output int toggles,
                           output int bad_iv, output int acks);
    logic prev;
    int   last_t;
    bit   done;
    n = 1; toggles = 0; bad_iv = 0; acks = 0;
    prev = BLANK; last_t = -1; done = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (ACTIVE_SRC == 2'd0) begin
        done = 1;
        break;
      end
      n++;
      if (BLANK != prev) begin
        toggles++;
        if (last_t >= 0 && (n - last_t) != 10) bad_iv++;
        last_t = n;
        prev = BLANK;
      end
      if (MSG1_ACK || MSG2_ACK) acks++;
    end
    chk({tag, "_return_seen"}, 32'(done), 32'd1);
  endtask

  task automatic do_reset;
    @(negedge CLK);
    RESET = 1'b1;
    MSG1_REQ = 1'b0;
    MSG2_REQ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  int n, tg, biv, ac;

  initial begin
    vecs[0] = '{bg: 16'h1234, exp_num: 16'h1234, exp_src: 2'd0};
    vecs[1] = '{bg: 16'hFFFF, exp_num: 16'hFFFF, exp_src: 2'd0};
    vecs[2] = '{bg: 16'h0000, exp_num: 16'h0000, exp_src: 2'd0};
    vecs[3] = '{bg: 16'hA5C3, exp_num: 16'hA5C3, exp_src: 2'd0};
    vecs[4] = '{bg: 16'h8001, exp_num: 16'h8001, exp_src: 2'd0};

    RESET = 1'b1;
    BG_DIGITS = 16'h1234;
    MSG1_REQ = 1'b0; MSG1_DIGITS = '0; MSG1_BLINK = 1'b0;
    MSG2_REQ = 1'b0; MSG2_DIGITS = '0; MSG2_BLINK = 1'b0;

    // 1. Reset values and background path
    step();
    chk("rst_num", 32'(num_all), 32'h0);
    chk("rst_src", 32'(ACTIVE_SRC), 32'h0);
    chk("rst_blank", 32'(BLANK), 32'h0);
    chk("rst_acks", 32'({MSG1_ACK, MSG2_ACK}), 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("rel_num_before_edge", 32'(num_all), 32'h0);
    step();
    chk("bg_first_num", 32'(num_all), 32'h1234);
    chk("bg_first_src", 32'(ACTIVE_SRC), 32'h0);
    chk("bg_first_acks", 32'({MSG1_ACK, MSG2_ACK}), 32'h0);

    foreach (vecs[i]) begin
      @(negedge CLK);
      BG_DIGITS = vecs[i].bg;
      step();
      chk($sformatf("bg_vec%0d_num", i), 32'(num_all), 32'(vecs[i].exp_num));
      chk($sformatf("bg_vec%0d_src", i), 32'(ACTIVE_SRC), 32'(vecs[i].exp_src));
      chk($sformatf("bg_vec%0d_blank", i), 32'(BLANK), 32'h0);
    end
    @(negedge CLK);
    BG_DIGITS = 16'h1234;

    // 2. Single MSG1 request, no blink
    @(negedge CLK);
    MSG1_REQ = 1'b1; MSG1_DIGITS = 16'hBEEF; MSG1_BLINK = 1'b0;
    step();
    chk("m1_ack", 32'(MSG1_ACK), 32'h1);
    chk("m1_num", 32'(num_all), 32'hBEEF);
    chk("m1_src", 32'(ACTIVE_SRC), 32'h1);
    @(negedge CLK);
    MSG1_REQ = 1'b0;
    wait_idle("m1", n, tg, biv, ac);
    chk_range("m1_show_cycles", n, 31, 40);
    chk("m1_ack_pulses", 32'(ac), 32'h0);
    chk("m1_blank_toggles", 32'(tg), 32'h0);
    chk("m1_ret_num", 32'(num_all), 32'h1234);
    chk("m1_ret_blank", 32'(BLANK), 32'h0);

    // 3. Tie right after reset: MSG2 first, then MSG1, then MSG2 again.
    // Requests are up before the first edge after release, so the grant
    // lands when the tick counter reads 1; ticks then occur 9 cycles later
    // and every 10, so each message is on display for exactly 39 cycles.
    do_reset();
    MSG1_REQ = 1'b1; MSG1_DIGITS = 16'h1111; MSG1_BLINK = 1'b0;
    MSG2_REQ = 1'b1; MSG2_DIGITS = 16'h2222; MSG2_BLINK = 1'b0;
    step();
    chk("tie1_ack2", 32'(MSG2_ACK), 32'h1);
    chk("tie1_ack1", 32'(MSG1_ACK), 32'h0);
    chk("tie1_src", 32'(ACTIVE_SRC), 32'h2);
    chk("tie1_num", 32'(num_all), 32'h2222);
    @(negedge CLK);
    MSG2_REQ = 1'b0;
    wait_idle("tie1", n, tg, biv, ac);
    chk("tie1_show_cycles", 32'(n), 32'd39);
    chk("tie1_no_ack", 32'(ac), 32'h0);
    chk("tie1_idle_num", 32'(num_all), 32'h1234);
    chk("tie1_idle_ack1", 32'(MSG1_ACK), 32'h0);
    step();
    chk("tie1_m1_ack", 32'(MSG1_ACK), 32'h1);
    chk("tie1_m1_src", 32'(ACTIVE_SRC), 32'h1);
    chk("tie1_m1_num", 32'(num_all), 32'h1111);
    @(negedge CLK);
    MSG1_REQ = 1'b0;
    wait_idle("tie1_m1", n, tg, biv, ac);
    chk("tie1_m1_show_cycles", 32'(n), 32'd39);
    @(negedge CLK);
    MSG1_REQ = 1'b1;
    MSG2_REQ = 1'b1;
    step();
    chk("tie2_ack2", 32'(MSG2_ACK), 32'h1);
    chk("tie2_ack1", 32'(MSG1_ACK), 32'h0);
    @(negedge CLK);
    MSG1_REQ = 1'b0;
    MSG2_REQ = 1'b0;
    wait_idle("tie2", n, tg, biv, ac);
    chk_range("tie2_show_cycles", n, 31, 40);

    // 4. Blinking MSG2: toggles on ticks 1..3, the 4th tick returns unblanked
    @(negedge CLK);
    MSG2_REQ = 1'b1; MSG2_DIGITS = 16'hCAFE; MSG2_BLINK = 1'b1;
    step();
    chk("blk_ack2", 32'(MSG2_ACK), 32'h1);
    chk("blk_blank_start", 32'(BLANK), 32'h0);
    chk("blk_num", 32'(num_all), 32'hCAFE);
    @(negedge CLK);
    MSG2_REQ = 1'b0; MSG2_BLINK = 1'b0;
    wait_idle("blk", n, tg, biv, ac);
    chk("blk_toggles", 32'(tg), 32'd3);
    chk("blk_bad_intervals", 32'(biv), 32'd0);
    chk("blk_ret_blank", 32'(BLANK), 32'h0);
    chk("blk_ret_num", 32'(num_all), 32'h1234);

    // 5. No preemption: MSG2 arrives mid-show, granted one cycle after exit
    @(negedge CLK);
    MSG1_REQ = 1'b1; MSG1_DIGITS = 16'h0F0F; MSG1_BLINK = 1'b0;
    step();
    chk("np_ack1", 32'(MSG1_ACK), 32'h1);
    @(negedge CLK);
    MSG1_REQ = 1'b0;
    repeat (5) step();
    @(negedge CLK);
    MSG2_REQ = 1'b1; MSG2_DIGITS = 16'h7777; MSG2_BLINK = 1'b0;
    wait_idle("np", n, tg, biv, ac);
    chk("np_no_ack_in_show", 32'(ac), 32'h0);
    chk("np_exit_ack2", 32'(MSG2_ACK), 32'h0);
    chk("np_exit_num", 32'(num_all), 32'h1234);
    step();
    chk("np_ack2", 32'(MSG2_ACK), 32'h1);
    chk("np_src", 32'(ACTIVE_SRC), 32'h2);
    chk("np_num", 32'(num_all), 32'h7777);
    @(negedge CLK);
    MSG2_REQ = 1'b0;
    wait_idle("np2", n, tg, biv, ac);

    // 6. Reset mid-show while MSG2_REQ stays held
    @(negedge CLK);
    MSG2_REQ = 1'b1; MSG2_DIGITS = 16'h5A5A; MSG2_BLINK = 1'b1;
    step();
    chk("rs_ack2", 32'(MSG2_ACK), 32'h1);
    repeat (6) step();
    chk("rs_in_show_src", 32'(ACTIVE_SRC), 32'h2);
    #2;
    RESET = 1'b1;
    #1;
    chk("rs_async_num", 32'(num_all), 32'h0);
    chk("rs_async_src", 32'(ACTIVE_SRC), 32'h0);
    chk("rs_async_blank", 32'(BLANK), 32'h0);
    step();
    chk("rs_held_ack2", 32'(MSG2_ACK), 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("rs_rel_ack2", 32'(MSG2_ACK), 32'h0);
    // First edge after release samples REQ; the ACK is then visible
    step();
    chk("rs_regrant_ack2", 32'(MSG2_ACK), 32'h1);
    chk("rs_regrant_src", 32'(ACTIVE_SRC), 32'h2);
    chk("rs_regrant_num", 32'(num_all), 32'h5A5A);
    @(negedge CLK);
    MSG2_REQ = 1'b0;
    wait_idle("rs", n, tg, biv, ac);
    chk("rs_show_cycles", 32'(n), 32'd39);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
